// File: rtl/bit_unstuff.sv
// Receive-side bit unstuffer: strips the zero inserted after every run of MAX_ONES
// ones, forwards the first PASS_BITS bits of a packet untouched, flags stuffing violations.
module bit_unstuff #(
    parameter int PASS_BITS = 16,
    parameter int MAX_ONES  = 6,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic eop,
    output logic bit_out,
    output logic bit_out_valid,
    output logic stuff_err,
    output logic done,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        DATA,
        DROP,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(PASS_BITS - 1);
    localparam logic [CNT_W-1:0] ONES_LAST = CNT_W'(MAX_ONES - 1);

    state_t           state;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] ones_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pass_cnt      <= '0;
            ones_cnt      <= '0;
            bit_out       <= 1'b0;
            bit_out_valid <= 1'b0;
            stuff_err     <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Pulse outputs default low; bit_out is forced to 0 when not valid.
            bit_out       <= 1'b0;
            bit_out_valid <= 1'b0;
            stuff_err     <= 1'b0;
            done          <= 1'b0;

            if (state == IDLE) begin
                if (start) begin
                    pass_cnt <= '0;
                    ones_cnt <= '0;
                    state    <= PASS;
                    busy     <= 1'b1;
                end
            end else if (eop) begin
                // eop wins over a coincident bit; a pending stuffed zero is not an error.
                done     <= 1'b1;
                busy     <= 1'b0;
                pass_cnt <= '0;
                ones_cnt <= '0;
                state    <= IDLE;
            end else if (bit_valid) begin
                case (state)
                    PASS: begin
                        bit_out       <= bit_in;
                        bit_out_valid <= 1'b1;
                        pass_cnt      <= pass_cnt + 1'b1;
                        if (pass_cnt == PASS_LAST) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        bit_out       <= bit_in;
                        bit_out_valid <= 1'b1;
                        if (bit_in) begin
                            ones_cnt <= ones_cnt + 1'b1;
                            if (ones_cnt == ONES_LAST) begin
                                state <= DROP;
                            end
                        end else begin
                            ones_cnt <= '0;
                        end
                    end
                    DROP: begin
                        ones_cnt <= '0;
                        if (bit_in) begin
                            stuff_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                    default: begin
                        // ERR discards everything until eop.
                    end
                endcase
            end
        end
    end

endmodule
